// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// The unsigned borrow helper lets the divider ignore the ALU flag outputs.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic       MD_MUL  = 1'b0;
    localparam logic       MD_DIVU = 1'b1;
    localparam int         STEPS   = 32;

    // Unsigned borrow of a - b, rebuilt from the operand and result sign bits.
    function automatic logic sub_borrow(input logic a_msb, input logic b_msb, input logic c_msb);
        return (~a_msb & b_msb) | (~(a_msb ^ b_msb) & c_msb);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Request/result handshake plus the shared-ALU operand lines of the muldiv sequencer.
// The slave side is the sequencer; the master side is the execute stage and its ALU.
interface alu_seq_muldiv_if;
    logic        iStart;
    logic        iOp;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult;
    logic [31:0] oRemainder;
    logic        oDivZero;
    logic [3:0]  oAluOP;
    logic [31:0] oAluA;
    logic [31:0] oAluB;
    logic [31:0] iAluC;

    modport slave (
        input  iStart, iOp, iA, iB, iAluC,
        output oBusy, oDone, oResult, oRemainder, oDivZero, oAluOP, oAluA, oAluB
    );

    modport master (
        output iStart, iOp, iA, iB, iAluC,
        input  oBusy, oDone, oResult, oRemainder, oDivZero, oAluOP, oAluA, oAluB
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle unsigned MUL / DIVU sequencer: one shift-add or restoring shift-subtract
// step per cycle through the CPU's external add/subtract ALU.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    alu_seq_muldiv_if.slave       bus
);
    import muldiv_pkg::*;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] acc_r;        // MUL accumulator / DIVU partial remainder
    logic [WIDTH-1:0] opa_r;        // MUL multiplicand / DIVU quotient (dividend shifts out)
    logic [WIDTH-1:0] opb_r;        // MUL multiplier / DIVU divisor
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] remainder_r;
    logic             op_r;
    logic             divzero_r;

    logic             start_s;
    logic             dz_start_s;
    logic             last_s;
    logic             borrow_s;
    logic             take_s;
    logic [WIDTH-1:0] r_prime_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] opa_nxt_s;
    logic [WIDTH-1:0] opb_nxt_s;

    // Start qualification: requests during RUN are dropped, divide-by-zero skips RUN.
    always_comb begin
        start_s    = bus.iStart & (state_r != RUN);
        dz_start_s = start_s & (bus.iOp == MD_DIVU) & (bus.iB == {WIDTH{1'b0}});
        last_s     = (cnt_r == 5'(STEPS - 1));
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (dz_start_s) begin
                    state_nxt_s = DONE;
                end else if (start_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // One iteration step; top bit of the shifted remainder forces a subtract.
    always_comb begin
        r_prime_s = {acc_r[WIDTH-2:0], opa_r[WIDTH-1]};
        borrow_s  = sub_borrow(r_prime_s[WIDTH-1], opb_r[WIDTH-1], bus.iAluC[WIDTH-1]);
        take_s    = acc_r[WIDTH-1] | ~borrow_s;
        acc_nxt_s = acc_r;
        opa_nxt_s = opa_r;
        opb_nxt_s = opb_r;
        if (op_r == MD_MUL) begin
            acc_nxt_s = opb_r[0] ? bus.iAluC : acc_r;
            opa_nxt_s = opa_r << 5'd1;
            opb_nxt_s = opb_r >> 5'd1;
        end else begin
            acc_nxt_s = take_s ? bus.iAluC : r_prime_s;
            opa_nxt_s = {opa_r[WIDTH-2:0], take_s};
            opb_nxt_s = opb_r;
        end
    end

    // Shared ALU drive: only owned while iterating, parked on ADD 0+0 otherwise.
    always_comb begin
        if (state_r == RUN) begin
            bus.oAluOP = (op_r == MD_MUL) ? ALU_ADD : ALU_SUB;
            bus.oAluA  = (op_r == MD_MUL) ? acc_r : r_prime_s;
            bus.oAluB  = (op_r == MD_MUL) ? opa_r : opb_r;
        end else begin
            bus.oAluOP = ALU_ADD;
            bus.oAluA  = {WIDTH{1'b0}};
            bus.oAluB  = {WIDTH{1'b0}};
        end
    end

    // Datapath registers: operand latch on start, step update in RUN, result on last step.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt_r       <= 5'd0;
            acc_r       <= {WIDTH{1'b0}};
            opa_r       <= {WIDTH{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            op_r        <= MD_MUL;
            divzero_r   <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= 5'd0;
            acc_r     <= {WIDTH{1'b0}};
            opa_r     <= bus.iA;
            opb_r     <= bus.iB;
            op_r      <= bus.iOp;
            divzero_r <= dz_start_s;
            if (dz_start_s) begin
                result_r    <= {WIDTH{1'b1}};
                remainder_r <= bus.iA;
            end
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + 5'd1;
            acc_r <= acc_nxt_s;
            opa_r <= opa_nxt_s;
            opb_r <= opb_nxt_s;
            if (last_s) begin
                result_r    <= (op_r == MD_MUL) ? acc_nxt_s : opa_nxt_s;
                remainder_r <= (op_r == MD_MUL) ? {WIDTH{1'b0}} : acc_nxt_s;
            end
        end
    end

    assign bus.oBusy      = (state_r == RUN);
    assign bus.oDone      = (state_r == DONE);
    assign bus.oResult    = result_r;
    assign bus.oRemainder = remainder_r;
    assign bus.oDivZero   = divzero_r;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv with a behavioural model of the external ALU.
module tb_alu_seq_muldiv;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_muldiv_if bus();

    alu_seq_muldiv #(.WIDTH(32), .STEPS(32)) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    // External CPU ALU
    always_comb begin
        case (bus.oAluOP)
            4'h1:    bus.iAluC = bus.oAluA + bus.oAluB;
            4'h2:    bus.iAluC = bus.oAluA - bus.oAluB;
            default: bus.iAluC = 32'h0;
        endcase
    end

    // Drive a start at the current negedge and record the expected outcome.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz = (op == MD_DIVU) && (b == 32'h0);
        if (op == MD_MUL) begin
            e.res = a * b; e.rem = 32'h0; e.lat = 33;
        end else if (b == 32'h0) begin
            e.res = 32'hFFFF_FFFF; e.rem = a; e.lat = 1;
        end else begin
            e.res = a / b; e.rem = a % b; e.lat = 33;
        end
        sb.push_back(e);
        bus.iStart = 1'b1; bus.iOp = op; bus.iA = a; bus.iB = b;
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    // Wait for oDone (optionally poking iStart mid-RUN) and compare against the scoreboard.
    task automatic wait_done(input string name, input int poke_at);
        exp_t e;
        int   k = 1;
        int   busy = 0;
        bit   got = 1'b0;
        while (k <= 100 && !got) begin
            if (bus.oDone) begin
                got = 1'b1;
            end else begin
                if (bus.oBusy) busy++;
                if (k == poke_at) begin
                    bus.iStart = 1'b1; bus.iOp = MD_MUL; bus.iA = 32'd99; bus.iB = 32'd3;
                end else begin
                    bus.iStart = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        bus.iStart = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            failures++; $display("FAIL %s timeout waiting for done", name);
            return;
        end
        if (k !== e.lat) begin
            failures++; $display("FAIL %s latency got %0d want %0d", name, k, e.lat);
        end
        checks++;
        if (busy !== ((e.lat == 33) ? 32 : 0)) begin
            failures++; $display("FAIL %s busy cycles got %0d want %0d", name, busy, (e.lat == 33) ? 32 : 0);
        end
        checks++;
        if (bus.oResult !== e.res) begin
            failures++; $display("FAIL %s result got %h want %h", name, bus.oResult, e.res);
        end
        checks++;
        if (bus.oRemainder !== e.rem) begin
            failures++; $display("FAIL %s remainder got %h want %h", name, bus.oRemainder, e.rem);
        end
        checks++;
        if (bus.oDivZero !== e.dz) begin
            failures++; $display("FAIL %s divzero got %b want %b", name, bus.oDivZero, e.dz);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.oBusy, bus.oDone, bus.oDivZero} !== 3'b000) begin
            failures++; $display("FAIL %s busy/done/dz got %b want 000", name, {bus.oBusy, bus.oDone, bus.oDivZero});
        end
        checks++;
        if ({bus.oResult, bus.oRemainder} !== 64'h0) begin
            failures++; $display("FAIL %s result/rem got %h/%h want 0/0", name, bus.oResult, bus.oRemainder);
        end
        checks++;
        if ({bus.oAluOP, bus.oAluA, bus.oAluB} !== {4'h1, 64'h0}) begin
            failures++; $display("FAIL %s alu lines got %h %h %h want 1 0 0", name, bus.oAluOP, bus.oAluA, bus.oAluB);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        issue(MD_MUL, 32'd7, 32'd6);
        wait_done("mul_7x6", 0);
        @(negedge clk);
        checks++;
        if (bus.oDone !== 1'b0 || bus.oResult !== 32'd42) begin
            failures++; $display("FAIL mul_hold done=%b result=%h want done=0 result=0000002a", bus.oDone, bus.oResult);
        end
        issue(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mul_max", 0);
        for (int i = 0; i < 3; i++) begin
            issue(MD_MUL, $urandom, $urandom);
            wait_done("mul_rand", 0);
        end
    endtask

    task automatic test_divu();
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 0);
        issue(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("divu_top", 0);
        for (int i = 0; i < 3; i++) begin
            issue(MD_DIVU, $urandom, $urandom_range(1, 32'hFFFF));
            wait_done("divu_rand", 0);
        end
        issue(MD_DIVU, 32'd3, 32'hF000_0000);
        wait_done("divu_small", 0);
    endtask

    task automatic test_divzero();
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_done("divzero", 0);
    endtask

    task automatic test_back_to_back();
        issue(MD_MUL, 32'd123, 32'd456);
        wait_done("ignore_midrun", 10);
        issue(MD_DIVU, 32'd1000, 32'd33);
        wait_done("back_to_back", 0);
        issue(MD_DIVU, 32'd9, 32'd0);
        wait_done("b2b_divzero", 0);
        issue(MD_MUL, 32'd11, 32'd13);
        wait_done("b2b_after_dz", 0);
    endtask

    task automatic test_reset_midrun();
        issue(MD_MUL, 32'd50, 32'd60);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_midrun");
        rst_n = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        issue(MD_MUL, 32'd3, 32'd3);
        wait_done("mul_after_reset", 0);
    endtask

    initial begin
        bus.iStart = 1'b0;
        bus.iOp    = MD_MUL;
        bus.iA     = 32'h0;
        bus.iB     = 32'h0;
        test_reset();
        test_mul();
        test_divu();
        test_divzero();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
